arb_mux_reg: RTL and testbench

//  Parametrised N:1 datapath selector with a registered output stage and valid/ready handshake.

---
 rtl/arb_mux_reg_if.sv | 27 ++
 rtl/arb_mux_reg.sv | 88 ++++++++
 tb/tb_arb_mux_reg.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/arb_mux_reg_if.sv
// Bundle for the N:1 selector: per-channel producer side plus the registered consumer side.
// Handshake: a word moves when valid and ready are both high on a rising clk edge; ready may depend on valid, valid never waits on ready.
interface arb_mux_reg_if #(
    parameter int WIDTH = 12,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in;
    logic [N-1:0]       invalid;
    logic [N-1:0]       inready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out;
    logic               outvalid;
    logic               outready;
    logic [SELW-1:0]    outch;

    modport master (
        output in, invalid, sel, outready,
        input  inready, out, outvalid, outch
    );

    modport slave (
        input  in, invalid, sel, outready,
        output inready, out, outvalid, outch
    );
endinterface

// File: rtl/arb_mux_reg.sv
// N:1 datapath selector with a registered output word; MODE 0 uses an external select,
// MODE 1 arbitrates round-robin over the valid channels.
module arb_mux_reg #(
    parameter int  WIDTH = 12,
    parameter int  N     = 4,
    parameter int  MODE  = 0,
    localparam int SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    arb_mux_reg_if.slave    bus,
    output logic [SELW-1:0] ptr
);

    logic             load;
    logic             grant;
    logic [SELW-1:0]  g;
    logic [WIDTH-1:0] g_data;
    logic [WIDTH-1:0] out_q;
    logic [SELW-1:0]  outch_q;
    logic             outvalid_q;

    // The register can take a word when empty or when it is being drained this same cycle.
    assign load = !outvalid_q || bus.outready;

    always_comb begin : grant_logic
        int t;
        grant = 1'b0;
        g     = '0;
        t     = 0;
        if (MODE == 0) begin
            // Comparing against every legal index means an out-of-range sel simply matches nothing.
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SELW'(i) && bus.invalid[i]) begin
                    grant = 1'b1;
                    g     = SELW'(i);
                end
            end
        end else begin
            // Visit ptr+1, ptr+2, ... modulo N; the first valid channel wins.
            for (int k = 1; k <= N; k++) begin
                t = int'(ptr) + k;
                if (t >= N) t = t - N;
                for (int i = 0; i < N; i++) begin
                    if (!grant && t == i && bus.invalid[i]) begin
                        grant = 1'b1;
                        g     = SELW'(i);
                    end
                end
            end
        end
    end

    always_comb begin : data_mux
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) g_data = bus.in[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin : ready_decode
        bus.inready = '0;
        for (int i = 0; i < N; i++) begin
            bus.inready[i] = rst && load && grant && (g == SELW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q      <= '0;
            outch_q    <= '0;
            outvalid_q <= 1'b0;
            ptr        <= SELW'(N-1);
        end else if (load && grant) begin
            out_q      <= g_data;
            outch_q    <= g;
            outvalid_q <= 1'b1;
            if (MODE == 1) ptr <= g;
        end else if (outvalid_q && bus.outready) begin
            outvalid_q <= 1'b0;
        end
    end

    assign bus.out      = out_q;
    assign bus.outch    = outch_q;
    assign bus.outvalid = outvalid_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: external-select and round-robin instances at N=4 and N=3.
module tb_arb_mux_reg;

  logic clk;
  logic rst;
  int n_cmp;
  int n_err;

  logic [1:0] ptr0, ptr1, ptr2, ptr3;

  arb_mux_reg_if #(.WIDTH(12), .N(4)) b0 ();
  arb_mux_reg_if #(.WIDTH(12), .N(3)) b1 ();
  arb_mux_reg_if #(.WIDTH(12), .N(4)) b2 ();
  arb_mux_reg_if #(.WIDTH(12), .N(3)) b3 ();

  arb_mux_reg #(.WIDTH(12), .N(4), .MODE(0)) u_m0n4 (.clk(clk), .rst(rst), .bus(b0), .ptr(ptr0));
  arb_mux_reg #(.WIDTH(12), .N(3), .MODE(0)) u_m0n3 (.clk(clk), .rst(rst), .bus(b1), .ptr(ptr1));
  arb_mux_reg #(.WIDTH(12), .N(4), .MODE(1)) u_m1n4 (.clk(clk), .rst(rst), .bus(b2), .ptr(ptr2));
  arb_mux_reg #(.WIDTH(12), .N(3), .MODE(1)) u_m1n3 (.clk(clk), .rst(rst), .bus(b3), .ptr(ptr3));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_all();
    b0.in = '0; b0.invalid = '0; b0.sel = '0; b0.outready = 1'b1;
    b1.in = '0; b1.invalid = '0; b1.sel = '0; b1.outready = 1'b1;
    b2.in = '0; b2.invalid = '0; b2.sel = '0; b2.outready = 1'b1;
    b3.in = '0; b3.invalid = '0; b3.sel = '0; b3.outready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_all();
    b0.invalid = 4'hF; b2.invalid = 4'hF;
    #2;
    n_cmp++; if (b0.outvalid !== 1'b0) begin n_err++; $display("FAIL rst_outvalid0: got %b want 0", b0.outvalid); end
    n_cmp++; if (b0.out !== 12'h000) begin n_err++; $display("FAIL rst_out0: got %h want 000", b0.out); end
    n_cmp++; if (b2.outch !== 2'd0) begin n_err++; $display("FAIL rst_outch2: got %0d want 0", b2.outch); end
    @(posedge clk); #1;
    n_cmp++; if (b0.inready !== 4'b0000) begin n_err++; $display("FAIL rst_inready0: got %b want 0000", b0.inready); end
    n_cmp++; if (b2.inready !== 4'b0000) begin n_err++; $display("FAIL rst_inready2: got %b want 0000", b2.inready); end
    n_cmp++; if (b2.outvalid !== 1'b0) begin n_err++; $display("FAIL rst_outvalid2: got %b want 0", b2.outvalid); end
    n_cmp++; if (ptr2 !== 2'd3) begin n_err++; $display("FAIL rst_ptr2: got %0d want 3", ptr2); end
    n_cmp++; if (ptr3 !== 2'd2) begin n_err++; $display("FAIL rst_ptr3: got %0d want 2", ptr3); end
    @(negedge clk);
    b0.invalid = '0; b2.invalid = '0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0_select();
    b0.in = {12'h444, 12'h333, 12'h222, 12'h111};
    b0.invalid = 4'hF; b0.sel = 2'd2; b0.outready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (b0.inready !== 4'b0100) begin n_err++; $display("FAIL t1_inready[%0d]: got %b want 0100", k, b0.inready); end
      @(negedge clk);
      n_cmp++; if (b0.out !== 12'h333) begin n_err++; $display("FAIL t1_out[%0d]: got %h want 333", k, b0.out); end
      n_cmp++; if (b0.outch !== 2'd2) begin n_err++; $display("FAIL t1_outch[%0d]: got %0d want 2", k, b0.outch); end
      n_cmp++; if (b0.outvalid !== 1'b1) begin n_err++; $display("FAIL t1_outvalid[%0d]: got %b want 1", k, b0.outvalid); end
    end
  endtask

  task automatic test_mode0_no_grant();
    b0.sel = 2'd3; b0.invalid = 4'b0111;
    #1;
    n_cmp++; if (b0.inready !== 4'b0000) begin n_err++; $display("FAIL t2_inready: got %b want 0000", b0.inready); end
    @(negedge clk);
    n_cmp++; if (b0.outvalid !== 1'b0) begin n_err++; $display("FAIL t2_drain: got %b want 0", b0.outvalid); end
    n_cmp++; if (b0.out !== 12'h333) begin n_err++; $display("FAIL t2_out_hold: got %h want 333", b0.out); end
    n_cmp++; if (b0.outch !== 2'd2) begin n_err++; $display("FAIL t2_outch_hold: got %0d want 2", b0.outch); end
    b0.invalid = '0;
    b1.in = {12'h0C3, 12'h0B2, 12'h0A1};
    b1.invalid = 3'b111; b1.sel = 2'd1; b1.outready = 1'b1;
    @(negedge clk);
    n_cmp++; if (b1.out !== 12'h0B2) begin n_err++; $display("FAIL t2_n3_out: got %h want 0b2", b1.out); end
    n_cmp++; if (b1.outch !== 2'd1) begin n_err++; $display("FAIL t2_n3_outch: got %0d want 1", b1.outch); end
    b1.sel = 2'd3;
    #1;
    n_cmp++; if (b1.inready !== 3'b000) begin n_err++; $display("FAIL t2_n3_inready: got %b want 000", b1.inready); end
    @(negedge clk);
    n_cmp++; if (b1.outvalid !== 1'b0) begin n_err++; $display("FAIL t2_n3_outvalid: got %b want 0", b1.outvalid); end
    n_cmp++; if ($isunknown(b1.out) || b1.out !== 12'h0B2) begin n_err++; $display("FAIL t2_n3_out_x: got %h want 0b2", b1.out); end
    b1.invalid = '0;
  endtask

  task automatic test_round_robin();
    int exp_a[5];
    int exp_b[4];
    logic [3:0] oh;
    exp_a = '{0, 1, 2, 3, 0};
    exp_b = '{1, 3, 1, 3};
    b2.in = {12'h103, 12'h102, 12'h101, 12'h100};
    b2.invalid = 4'hF; b2.outready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      oh = 4'b0001 << exp_a[k];
      n_cmp++; if (b2.inready !== oh) begin n_err++; $display("FAIL t3_inready[%0d]: got %b want %b", k, b2.inready, oh); end
      @(negedge clk);
      n_cmp++; if (b2.outch !== 2'(exp_a[k])) begin n_err++; $display("FAIL t3_outch[%0d]: got %0d want %0d", k, b2.outch, exp_a[k]); end
      n_cmp++; if (b2.out !== 12'(12'h100 + exp_a[k])) begin n_err++; $display("FAIL t3_out[%0d]: got %h want %h", k, b2.out, 12'h100 + exp_a[k]); end
      n_cmp++; if (b2.outvalid !== 1'b1) begin n_err++; $display("FAIL t3_outvalid[%0d]: got %b want 1", k, b2.outvalid); end
    end
    b2.invalid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      oh = 4'b0001 << exp_b[k];
      n_cmp++; if (b2.inready !== oh) begin n_err++; $display("FAIL t3b_inready[%0d]: got %b want %b", k, b2.inready, oh); end
      @(negedge clk);
      n_cmp++; if (b2.outch !== 2'(exp_b[k])) begin n_err++; $display("FAIL t3b_outch[%0d]: got %0d want %0d", k, b2.outch, exp_b[k]); end
    end
    b2.invalid = '0;
    @(negedge clk);
    n_cmp++; if (b2.outvalid !== 1'b0) begin n_err++; $display("FAIL t3_drain: got %b want 0", b2.outvalid); end
    n_cmp++; if (b2.outch !== 2'd3) begin n_err++; $display("FAIL t3_outch_hold: got %0d want 3", b2.outch); end
  endtask

  task automatic test_stall();
    b2.in = {12'h000, 12'h000, 12'h000, 12'h0AB};
    b2.invalid = 4'b0001; b2.outready = 1'b1;
    @(negedge clk);
    n_cmp++; if (b2.out !== 12'h0AB) begin n_err++; $display("FAIL t4_load: got %h want 0ab", b2.out); end
    b2.outready = 1'b0;
    b2.invalid = 4'b0010; b2.in[23:12] = 12'h0CD;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        b2.invalid = 4'b0110; b2.in[35:24] = 12'h0EF; b2.sel = 2'd3;
      end
      #1;
      n_cmp++; if (b2.inready !== 4'b0000) begin n_err++; $display("FAIL t4_inready[%0d]: got %b want 0000", k, b2.inready); end
      @(negedge clk);
      n_cmp++; if (b2.out !== 12'h0AB) begin n_err++; $display("FAIL t4_out[%0d]: got %h want 0ab", k, b2.out); end
      n_cmp++; if (b2.outvalid !== 1'b1 || b2.outch !== 2'd0) begin n_err++; $display("FAIL t4_hold[%0d]: got v=%b ch=%0d want v=1 ch=0", k, b2.outvalid, b2.outch); end
    end
    b2.outready = 1'b1;
    #1;
    n_cmp++; if (b2.inready !== 4'b0010) begin n_err++; $display("FAIL t4_release_inready: got %b want 0010", b2.inready); end
    @(negedge clk);
    n_cmp++; if (b2.out !== 12'h0CD || b2.outch !== 2'd1) begin n_err++; $display("FAIL t4_next: got %h/%0d want 0cd/1", b2.out, b2.outch); end
    n_cmp++; if (ptr2 !== 2'd1) begin n_err++; $display("FAIL t4_ptr: got %0d want 1", ptr2); end
    b2.invalid = 4'b0100;
    #1;
    n_cmp++; if (b2.inready !== 4'b0100) begin n_err++; $display("FAIL t4_b2b_inready: got %b want 0100", b2.inready); end
    @(negedge clk);
    n_cmp++; if (b2.out !== 12'h0EF || b2.outch !== 2'd2) begin n_err++; $display("FAIL t4_b2b: got %h/%0d want 0ef/2", b2.out, b2.outch); end
    b2.invalid = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap_n3();
    int exp_c[4];
    logic [2:0] oh;
    exp_c = '{0, 2, 0, 2};
    b3.in = {12'h0A2, 12'h0A1, 12'h0A0};
    b3.invalid = 3'b101; b3.outready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      oh = 3'b001 << exp_c[k];
      n_cmp++; if (b3.inready !== oh) begin n_err++; $display("FAIL t5_inready[%0d]: got %b want %b", k, b3.inready, oh); end
      @(negedge clk);
      n_cmp++; if (b3.outch !== 2'(exp_c[k])) begin n_err++; $display("FAIL t5_outch[%0d]: got %0d want %0d", k, b3.outch, exp_c[k]); end
      n_cmp++; if (ptr3 !== 2'(exp_c[k])) begin n_err++; $display("FAIL t5_ptr[%0d]: got %0d want %0d", k, ptr3, exp_c[k]); end
      n_cmp++; if (b3.out !== 12'(12'h0A0 + exp_c[k])) begin n_err++; $display("FAIL t5_out[%0d]: got %h want %h", k, b3.out, 12'h0A0 + exp_c[k]); end
    end
    b3.invalid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    b2.in = {12'h0D3, 12'h0D2, 12'h0D1, 12'h0D0};
    b2.invalid = 4'hF; b2.outready = 1'b1;
    @(negedge clk);
    n_cmp++; if (b2.outvalid !== 1'b1 || b2.outch !== 2'd3) begin n_err++; $display("FAIL t6_pre: got v=%b ch=%0d want v=1 ch=3", b2.outvalid, b2.outch); end
    b2.outready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (b2.outvalid !== 1'b0) begin n_err++; $display("FAIL t6_outvalid: got %b want 0", b2.outvalid); end
    n_cmp++; if (b2.out !== 12'h000 || b2.outch !== 2'd0) begin n_err++; $display("FAIL t6_out: got %h/%0d want 000/0", b2.out, b2.outch); end
    n_cmp++; if (b2.inready !== 4'b0000) begin n_err++; $display("FAIL t6_inready: got %b want 0000", b2.inready); end
    n_cmp++; if (ptr2 !== 2'd3) begin n_err++; $display("FAIL t6_ptr: got %0d want 3", ptr2); end
    @(negedge clk);
    rst = 1'b1;
    b2.outready = 1'b1;
    #1;
    n_cmp++; if (b2.inready !== 4'b0001) begin n_err++; $display("FAIL t6_first_inready: got %b want 0001", b2.inready); end
    @(negedge clk);
    n_cmp++; if (b2.outch !== 2'd0 || b2.out !== 12'h0D0) begin n_err++; $display("FAIL t6_first: got %0d/%h want 0/0d0", b2.outch, b2.out); end
    b2.invalid = '0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_mode0_select();
    test_mode0_no_grant();
    test_round_robin();
    test_stall();
    test_wrap_n3();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
